// File: rtl/icache_refill_ctrl.sv
// icache_refill_ctrl
//
// Purpose: miss-side writer for the instruction cache tag/data arrays. On a
// miss it issues one line-sized burst read to memory, streams each returned
// beat straight into the data array, then writes {valid, tag} into the tag
// array with a one-cycle strobe and pulses done back to the fetch stage.
// A bus error (non-zero rresp) or a misplaced rlast suppresses the tag write
// so the line stays invalid and the fetch stage sees refill_err_o.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   miss_valid_i/addr   miss request from the hit logic (level)
//   refill_busy_o       controller is not idle
//   refill_done_o       one-cycle completion pulse, refill_err_o valid with it
//   mem_ar*             read address channel (line-aligned, arlen = BEATS-1)
//   mem_r*              read data channel
//   data_wr_*           data array beat write port
//   tag_wr_*            tag array write port
//
// Optional feature, enabled by defining ICACHE_REFILL_PERF_EN:
//   perf_refill_cnt_o   saturating count of completed refills
//   perf_refill_cyc_o   saturating count of busy cycles

module icache_refill_ctrl #(
    parameter int TAG_LEN    = 19,
    parameter int IDX_LEN    = 7,
    parameter int OFFSET_LEN = 6,
    parameter int ADDR_LEN   = 32,
    parameter int DATA_WIDTH = 64,
    parameter int BEATS      = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     miss_valid_i,
    input  logic [ADDR_LEN-1:0]      miss_addr_i,
    output logic                     refill_busy_o,
    output logic                     refill_done_o,
    output logic                     refill_err_o,
`ifdef ICACHE_REFILL_PERF_EN
    output logic [31:0]              perf_refill_cnt_o,
    output logic [31:0]              perf_refill_cyc_o,
`endif
    output logic                     mem_arvalid_o,
    input  logic                     mem_arready_i,
    output logic [ADDR_LEN-1:0]      mem_araddr_o,
    output logic [7:0]               mem_arlen_o,
    input  logic                     mem_rvalid_i,
    output logic                     mem_rready_o,
    input  logic [DATA_WIDTH-1:0]    mem_rdata_i,
    input  logic [1:0]               mem_rresp_i,
    input  logic                     mem_rlast_i,
    output logic                     data_wr_en_o,
    output logic [IDX_LEN-1:0]       data_wr_index_o,
    output logic [$clog2(BEATS)-1:0] data_wr_beat_o,
    output logic [DATA_WIDTH-1:0]    data_wr_data_o,
    output logic                     tag_wr_o,
    output logic [TAG_LEN-1:0]       tag_wr_tag_o,
    output logic [IDX_LEN-1:0]       tag_wr_index_o
);

    localparam int BEAT_W = $clog2(BEATS);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    typedef enum logic [2:0] {
        IDLE,
        AR,
        R,
        TAG,
        DONE
    } state_t;

    state_t              state_q;
    logic [BEAT_W-1:0]   beat_q;
    logic                err_q;
    logic [TAG_LEN-1:0]  tag_q;
    logic [IDX_LEN-1:0]  idx_q;

    logic beat_fire;
    logic beat_bad;

    // The byte offset of the missing address is irrelevant: the whole line
    // is fetched from its aligned start.
    logic unused_offset;
    assign unused_offset = ^miss_addr_i[OFFSET_LEN-1:0];

    assign beat_fire = (state_q == R) && mem_rvalid_i;

    // A beat is bad on a bus error, or when rlast disagrees with our own
    // beat count (early or missing rlast). The counter still ends the burst.
    assign beat_bad = (mem_rresp_i != 2'b00) || (mem_rlast_i != (beat_q == LAST_BEAT));

    // Main controller: state, beat counter, sticky error flag and the
    // tag/index captured from the miss address. The address is only sampled
    // in IDLE so that changes on miss_addr_i while busy have no effect.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            beat_q  <= '0;
            err_q   <= 1'b0;
            tag_q   <= '0;
            idx_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (miss_valid_i) begin
                        tag_q   <= miss_addr_i[ADDR_LEN-1 -: TAG_LEN];
                        idx_q   <= miss_addr_i[OFFSET_LEN +: IDX_LEN];
                        err_q   <= 1'b0;
                        state_q <= AR;
                    end
                end
                AR: begin
                    if (mem_arready_i) begin
                        beat_q  <= '0;
                        state_q <= R;
                    end
                end
                R: begin
                    if (beat_fire) begin
                        beat_q <= beat_q + 1'b1;
                        if (beat_bad) begin
                            err_q <= 1'b1;
                        end
                        if (beat_q == LAST_BEAT) begin
                            state_q <= TAG;
                        end
                    end
                end
                TAG: begin
                    state_q <= DONE;
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Control outputs are decoded purely from the state register, so an
    // asynchronous reset drops every one of them without waiting for a clock.
    // data_wr_en_o additionally follows rvalid so a beat lands in the same
    // cycle it is accepted.
    assign refill_busy_o   = (state_q != IDLE);
    assign mem_arvalid_o   = (state_q == AR);
    assign mem_araddr_o    = {tag_q, idx_q, {OFFSET_LEN{1'b0}}};
    assign mem_arlen_o     = 8'(BEATS - 1);
    assign mem_rready_o    = (state_q == R);

    assign data_wr_en_o    = beat_fire;
    assign data_wr_index_o = idx_q;
    assign data_wr_beat_o  = beat_q;
    assign data_wr_data_o  = mem_rdata_i;

    assign tag_wr_o        = (state_q == TAG) && !err_q;
    assign tag_wr_tag_o    = tag_q;
    assign tag_wr_index_o  = idx_q;

    assign refill_done_o   = (state_q == DONE);
    assign refill_err_o    = (state_q == DONE) && err_q;

`ifdef ICACHE_REFILL_PERF_EN
    logic [31:0] perf_cnt_q;
    logic [31:0] perf_cyc_q;

    // Saturating performance counters: completed refills and busy cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_cnt_q <= '0;
            perf_cyc_q <= '0;
        end else begin
            if ((state_q == DONE) && (perf_cnt_q != 32'hFFFF_FFFF)) begin
                perf_cnt_q <= perf_cnt_q + 32'd1;
            end
            if ((state_q != IDLE) && (perf_cyc_q != 32'hFFFF_FFFF)) begin
                perf_cyc_q <= perf_cyc_q + 32'd1;
            end
        end
    end

    assign perf_refill_cnt_o = perf_cnt_q;
    assign perf_refill_cyc_o = perf_cyc_q;
`endif

endmodule
